// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad scanner types and key-to-BCD lookup
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    PRESSED,
    RELEASE
  } kp_state_e;

  localparam logic [3:0] KEY_NONE_BCD = 4'hF;

  // Layout r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] key_to_bcd(input logic [3:0] code);
    case (code)
      4'd0:    return 4'd1;
      4'd1:    return 4'd2;
      4'd2:    return 4'd3;
      4'd4:    return 4'd4;
      4'd5:    return 4'd5;
      4'd6:    return 4'd6;
      4'd8:    return 4'd7;
      4'd9:    return 4'd8;
      4'd10:   return 4'd9;
      4'd13:   return 4'd0;
      default: return KEY_NONE_BCD;
    endcase
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser, resets to all ones (idle keypad columns)
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] s1_q;
  logic [W-1:0] s2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '1;
      s2_q <= '1;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 keypad row scanner with debounce, one pulse per press
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_N = 4,
  parameter int CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] key_bcd,
  output logic       key_is_num,
  output logic       key_held
);

  localparam logic [CNT_W-1:0] ACCEPT_AT = CNT_W'(DEBOUNCE_N - 1);

  kp_state_e        state_q, state_d;
  logic [1:0]       ridx_q, ridx_d;
  logic [1:0]       cidx_q, cidx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_q, valid_d;
  logic [3:0]       code_q, code_d;
  logic [3:0]       bcd_q, bcd_d;
  logic             held_q, held_d;

  logic [3:0] cs;
  logic [3:0] low;
  logic       one_low;
  logic [1:0] low_idx;
  logic       col_match;
  logic       all_high;

  sync_2ff #(.W(4)) u_col_sync (
    .clk (clk),
    .rst (rst),
    .d_i (col),
    .q_o (cs)
  );

  assign low       = ~cs;
  assign one_low   = (low != 4'b0000) && ((low & (low - 4'd1)) == 4'b0000);
  assign all_high  = (cs == 4'b1111);
  assign col_match = (cs == ~(4'b0001 << cidx_q));

  always_comb begin
    low_idx = 2'd0;
    case (low)
      4'b0010: low_idx = 2'd1;
      4'b0100: low_idx = 2'd2;
      4'b1000: low_idx = 2'd3;
      default: low_idx = 2'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SCAN;
      ridx_q  <= 2'd0;
      cidx_q  <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= 4'd0;
      bcd_q   <= KEY_NONE_BCD;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ridx_q  <= ridx_d;
      cidx_q  <= cidx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      bcd_q   <= bcd_d;
      held_q  <= held_d;
    end
  end

  // Row stays frozen from detection until the release is debounced
  always_comb begin
    state_d = state_q;
    ridx_d  = ridx_q;
    cidx_d  = cidx_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    code_d  = code_q;
    bcd_d   = bcd_q;
    held_d  = held_q;
    if (tick) begin
      case (state_q)
        SCAN: begin
          if (one_low) begin
            cidx_d  = low_idx;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end else begin
            ridx_d = ridx_q + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (!col_match) begin
            state_d = SCAN;
            ridx_d  = ridx_q + 2'd1;
          end else if (cnt_q >= ACCEPT_AT) begin
            state_d = PRESSED;
            valid_d = 1'b1;
            code_d  = {ridx_q, cidx_q};
            bcd_d   = key_to_bcd({ridx_q, cidx_q});
            held_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        PRESSED: begin
          if (all_high) begin
            state_d = RELEASE;
            cnt_d   = CNT_W'(1);
          end
        end
        RELEASE: begin
          if (!all_high) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q >= ACCEPT_AT) begin
            state_d = SCAN;
            held_d  = 1'b0;
            ridx_d  = ridx_q + 2'd1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  assign row        = ~(4'b0001 << ridx_q);
  assign key_valid  = valid_q;
  assign key_code   = code_q;
  assign key_bcd    = bcd_q;
  assign key_is_num = (bcd_q != KEY_NONE_BCD);
  assign key_held   = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed table-driven bench for keypad_scan
module tb_keypad_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_bcd;
  logic       key_is_num;
  logic       key_held;

  logic [15:0] keys = 16'h0;
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    int         r;
    int         c;
    logic [3:0] code;
    logic [3:0] bcd;
    logic       num;
  } vec_t;

  vec_t vecs[7];

  keypad_scan #(.DEBOUNCE_N(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .col        (col),
    .row        (row),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_bcd    (key_bcd),
    .key_is_num (key_is_num),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Passive keypad: a pressed key shorts its row line onto its column line
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row[r]) col[c] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid) begin
      pulses++;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL valid_consecutive actual=1 required=0");
      end
    end
    prev_valid = key_valid;
  end

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  task automatic tick_once();
    repeat (7) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick_once();
  endtask

  task automatic wait_pulse(input string name, input int target);
    for (int i = 0; i < 24 && pulses < target; i++) tick_once();
    chk(name, pulses, target);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_row"}, int'(row), 4'b1110);
    chk({tag, "_valid"}, int'(key_valid), 0);
    chk({tag, "_code"}, int'(key_code), 0);
    chk({tag, "_bcd"}, int'(key_bcd), 15);
    chk({tag, "_num"}, int'(key_is_num), 0);
    chk({tag, "_held"}, int'(key_held), 0);
  endtask

  initial begin
    int base;
    vecs[0] = '{1, 1, 4'd5,  4'd5, 1'b1};
    vecs[1] = '{3, 1, 4'd13, 4'd0, 1'b1};
    vecs[2] = '{3, 0, 4'd12, 4'hF, 1'b0};
    vecs[3] = '{0, 3, 4'd3,  4'hF, 1'b0};
    vecs[4] = '{0, 0, 4'd0,  4'd1, 1'b1};
    vecs[5] = '{2, 2, 4'd10, 4'd9, 1'b1};
    vecs[6] = '{3, 2, 4'd14, 4'hF, 1'b0};

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // Exact latency from reset: key (0,0) seen on tick 1, accepted on tick 4
    keys = 16'h0001;
    tick_n(3);
    chk("latency_before", pulses, 0);
    tick_once();
    chk("latency_at", pulses, 1);
    chk("latency_code", int'(key_code), 0);
    keys = 16'h0;
    tick_n(6);
    chk("latency_release_held", int'(key_held), 0);

    foreach (vecs[i]) begin
      base = pulses;
      keys = 16'h0;
      keys[vecs[i].r*4+vecs[i].c] = 1'b1;
      wait_pulse($sformatf("vec%0d_pulse", i), base + 1);
      tick_n(10);
      chk($sformatf("vec%0d_once", i), pulses, base + 1);
      chk($sformatf("vec%0d_code", i), int'(key_code), int'(vecs[i].code));
      chk($sformatf("vec%0d_bcd", i), int'(key_bcd), int'(vecs[i].bcd));
      chk($sformatf("vec%0d_num", i), int'(key_is_num), int'(vecs[i].num));
      chk($sformatf("vec%0d_held", i), int'(key_held), 1);
      keys = 16'h0;
      tick_n(3);
      chk($sformatf("vec%0d_held_rel3", i), int'(key_held), 1);
      tick_once();
      chk($sformatf("vec%0d_held_rel4", i), int'(key_held), 0);
      chk($sformatf("vec%0d_code_kept", i), int'(key_code), int'(vecs[i].code));
    end

    // Press bounce on '0' with two-tick gaps, then stable
    base = pulses;
    keys = 16'h0; keys[13] = 1'b1; tick_once();
    keys = 16'h0; tick_n(2);
    keys[13] = 1'b1; tick_once();
    keys = 16'h0; tick_n(2);
    keys[13] = 1'b1;
    wait_pulse("bounce_pulse", base + 1);
    tick_n(6);
    chk("bounce_once", pulses, base + 1);
    chk("bounce_code", int'(key_code), 13);
    chk("bounce_bcd", int'(key_bcd), 0);
    keys = 16'h0;
    tick_n(6);

    // Glitch and two-column patterns from a fresh reset (ridx 0)
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    base = pulses;
    keys = 16'h0004;
    tick_n(2);
    keys = 16'h0;
    tick_once(); chk("glitch_row1", int'(row), 4'b1101);
    tick_once(); chk("glitch_row2", int'(row), 4'b1011);
    tick_once(); chk("glitch_row3", int'(row), 4'b0111);
    tick_once(); chk("glitch_row0", int'(row), 4'b1110);
    chk("glitch_nopulse", pulses, base);

    keys = 16'h0006;
    tick_once(); chk("twocol_row1", int'(row), 4'b1101);
    tick_n(7);
    chk("twocol_nopulse", pulses, base);

    // Long hold on '7' with a same-row second key and a release bounce
    keys = 16'h0; keys[8] = 1'b1;
    wait_pulse("hold_pulse", base + 1);
    chk("hold_code", int'(key_code), 8);
    chk("hold_bcd", int'(key_bcd), 7);
    keys[9] = 1'b1;
    tick_n(50);
    chk("hold_once", pulses, base + 1);
    chk("hold_row_frozen", int'(row), 4'b1011);
    keys = 16'h0; tick_once();
    keys[8] = 1'b1; tick_once();
    keys = 16'h0; tick_n(6);
    chk("hold_release_once", pulses, base + 1);
    chk("hold_released", int'(key_held), 0);
    keys[8] = 1'b1;
    wait_pulse("repress_pulse", base + 2);
    keys = 16'h0;
    tick_n(6);

    // Async reset during DEBOUNCE, then during PRESSED, key (0,0) kept down
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    base = pulses;
    keys = 16'h0001;
    tick_n(2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_deb");
    @(negedge clk); rst = 1'b0;
    tick_n(3);
    chk("rst_deb_nopulse", pulses, base);
    tick_once();
    chk("rst_deb_pulse", pulses, base + 1);
    chk("rst_deb_held", int'(key_held), 1);
    tick_n(2);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("rst_prs");
    @(negedge clk); rst = 1'b0;
    tick_n(3);
    chk("rst_prs_nopulse", pulses, base + 1);
    tick_once();
    chk("rst_prs_pulse", pulses, base + 2);
    chk("rst_prs_bcd", int'(key_bcd), 1);
    keys = 16'h0;
    tick_n(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
